// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM encoding, the starvation counter width and its legal range.
package core_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_BUSY  = 2'd1,
        ARB_DM_BUSY  = 2'd2,
        ARB_IF_DRAIN = 2'd3
    } arb_state_t;

    localparam int STARVE_CNT_W  = 4;
    localparam int STARVE_MAX_LO = 1;
    localparam int STARVE_MAX_HI = 15;

    // Out-of-range limits are pinned to the nearest legal value so the counter
    // can always reach its saturation point.
    function automatic logic [STARVE_CNT_W-1:0] starve_limit(input int value);
        int lim;
        lim = value;
        if (lim < STARVE_MAX_LO) lim = STARVE_MAX_LO;
        if (lim > STARVE_MAX_HI) lim = STARVE_MAX_HI;
        return STARVE_CNT_W'(lim);
    endfunction

endpackage

// File: rtl/core_arb_starve_cnt.sv
// Saturating count of DM grants made while a fetch is waiting.
// sat tells the arbiter to hand the next contended slot to IF.
module core_arb_starve_cnt
    import core_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = starve_limit(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == LIMIT);

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares the single memory port between instruction fetch and data access,
// one transaction at a time, DM first with a starvation guard for IF.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    input  logic              IF_FLUSH,
    output logic              IF_ACK,
    output logic [XLEN-1:0]   IF_RDATA,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [ADDR_W-1:0] DM_ADDR,
    input  logic [XLEN-1:0]   DM_WDATA,
    input  logic [XLEN/8-1:0] DM_WSTRB,
    output logic              DM_ACK,
    output logic [XLEN-1:0]   DM_RDATA,
    output logic              M_REQ,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [XLEN-1:0]   M_WDATA,
    output logic [XLEN/8-1:0] M_WSTRB,
    input  logic              M_ACK,
    input  logic [XLEN-1:0]   M_RDATA,
    output logic              ARB_IF_STALL,
    output logic              ARB_DM_STALL
);

    arb_state_t state;

    logic idle;
    logic if_ok;
    logic grant_if;
    logic grant_dm;
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    assign idle  = (state == ARB_IDLE);
    // A fetch being killed this cycle must not start a memory access.
    assign if_ok = IF_REQ & ~IF_FLUSH;

    assign grant_if = idle & if_ok & (~DM_REQ | starve_sat);
    assign grant_dm = idle & DM_REQ & ~grant_if;

    assign starve_inc = grant_dm & IF_REQ;
    assign starve_clr = grant_if | (idle & ~IF_REQ);

    core_arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk(CLK),
        .rst(RST),
        .inc(starve_inc),
        .clr(starve_clr),
        .sat(starve_sat)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ARB_IDLE;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            M_WSTRB <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_if) begin
                        state   <= ARB_IF_BUSY;
                        M_REQ   <= 1'b1;
                        M_WE    <= 1'b0;
                        M_ADDR  <= IF_ADDR;
                        M_WDATA <= '0;
                        M_WSTRB <= '0;
                    end else if (grant_dm) begin
                        state   <= ARB_DM_BUSY;
                        M_REQ   <= 1'b1;
                        M_WE    <= DM_WE;
                        M_ADDR  <= DM_ADDR;
                        M_WDATA <= DM_WDATA;
                        M_WSTRB <= DM_WSTRB;
                    end
                end
                ARB_IF_BUSY: begin
                    if (M_ACK) begin
                        state <= ARB_IDLE;
                        M_REQ <= 1'b0;
                    end else if (IF_FLUSH) begin
                        state <= ARB_IF_DRAIN;
                    end
                end
                ARB_DM_BUSY, ARB_IF_DRAIN: begin
                    if (M_ACK) begin
                        state <= ARB_IDLE;
                        M_REQ <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    M_REQ <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving with the ack still retires the access but hides it from IF.
    assign IF_ACK   = (state == ARB_IF_BUSY) & M_ACK & ~IF_FLUSH;
    assign DM_ACK   = (state == ARB_DM_BUSY) & M_ACK;
    assign IF_RDATA = M_RDATA;
    assign DM_RDATA = M_RDATA;

    assign ARB_IF_STALL = IF_REQ & ~IF_ACK;
    assign ARB_DM_STALL = DM_REQ & ~DM_ACK;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: drives 1 ns after the rising edge,
// samples on the falling edge against hand-computed values.
module tb_core_mem_arbiter;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              IF_REQ, IF_FLUSH, IF_ACK;
    logic [ADDR_W-1:0] IF_ADDR;
    logic [XLEN-1:0]   IF_RDATA;
    logic              DM_REQ, DM_WE, DM_ACK;
    logic [ADDR_W-1:0] DM_ADDR;
    logic [XLEN-1:0]   DM_WDATA, DM_RDATA;
    logic [XLEN/8-1:0] DM_WSTRB;
    logic              M_REQ, M_WE, M_ACK;
    logic [ADDR_W-1:0] M_ADDR;
    logic [XLEN-1:0]   M_WDATA, M_RDATA;
    logic [XLEN/8-1:0] M_WSTRB;
    logic              ARB_IF_STALL, ARB_DM_STALL;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    core_mem_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_FLUSH(IF_FLUSH),
        .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_WSTRB(DM_WSTRB), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
        .M_WSTRB(M_WSTRB), .M_ACK(M_ACK), .M_RDATA(M_RDATA),
        .ARB_IF_STALL(ARB_IF_STALL), .ARB_DM_STALL(ARB_DM_STALL)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; IF_REQ = 0; IF_FLUSH = 0; IF_ADDR = '0;
        DM_REQ = 0; DM_WE = 0; DM_ADDR = '0; DM_WDATA = '0; DM_WSTRB = '0;
        M_ACK = 0; M_RDATA = '0;
        next_cycle(); next_cycle();
        sample();
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL rst_mreq got %h want 0", M_REQ); end
        n_cmp++; if ({M_WE, M_ADDR, M_WDATA, M_WSTRB} !== '0) begin n_err++; $display("FAIL rst_mbus got %h/%h/%h/%h want all 0", M_WE, M_ADDR, M_WDATA, M_WSTRB); end
        n_cmp++; if ({IF_ACK, DM_ACK, ARB_IF_STALL, ARB_DM_STALL} !== 4'b0) begin n_err++; $display("FAIL rst_acks got %b want 0000", {IF_ACK, DM_ACK, ARB_IF_STALL, ARB_DM_STALL}); end
        next_cycle();
        RST = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        IF_REQ = 1; IF_ADDR = 32'h100;                      // cycle 0
        sample();
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL sf_mreq_c0 got %h want 0", M_REQ); end
        n_cmp++; if (ARB_IF_STALL !== 1'b1) begin n_err++; $display("FAIL sf_stall_c0 got %h want 1", ARB_IF_STALL); end
        next_cycle();                                        // cycle 1
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_ADDR !== 32'h100 || M_WE !== 1'b0) begin n_err++; $display("FAIL sf_mbus_c1 got req=%h addr=%h we=%h want 1/100/0", M_REQ, M_ADDR, M_WE); end
        n_cmp++; if (IF_ACK !== 1'b0) begin n_err++; $display("FAIL sf_ifack_c1 got %h want 0", IF_ACK); end
        next_cycle();                                        // cycle 2
        M_ACK = 1; M_RDATA = 32'h00500093;
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_ADDR !== 32'h100) begin n_err++; $display("FAIL sf_mbus_c2 got req=%h addr=%h want 1/100", M_REQ, M_ADDR); end
        n_cmp++; if (IF_ACK !== 1'b1 || IF_RDATA !== 32'h00500093) begin n_err++; $display("FAIL sf_ifack_c2 got ack=%h data=%h want 1/00500093", IF_ACK, IF_RDATA); end
        n_cmp++; if (ARB_IF_STALL !== 1'b0 || DM_ACK !== 1'b0) begin n_err++; $display("FAIL sf_stall_c2 got stall=%h dmack=%h want 0/0", ARB_IF_STALL, DM_ACK); end
        next_cycle();                                        // cycle 3
        IF_REQ = 0; M_ACK = 0;
        sample();
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL sf_mreq_c3 got %h want 0", M_REQ); end
        next_cycle();
    endtask

    task automatic test_contention();
        IF_REQ = 1; IF_ADDR = 32'h104;                       // cycle 0
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 32'h2000; DM_WDATA = 32'hDEADBEEF; DM_WSTRB = 4'hF;
        sample();
        n_cmp++; if (ARB_DM_STALL !== 1'b1) begin n_err++; $display("FAIL ct_dmstall_c0 got %h want 1", ARB_DM_STALL); end
        next_cycle();                                        // cycle 1
        M_ACK = 1; M_RDATA = 32'h0;
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_WE !== 1'b1 || M_ADDR !== 32'h2000) begin n_err++; $display("FAIL ct_dm_grant got req=%h we=%h addr=%h want 1/1/2000", M_REQ, M_WE, M_ADDR); end
        n_cmp++; if (M_WDATA !== 32'hDEADBEEF || M_WSTRB !== 4'hF) begin n_err++; $display("FAIL ct_dm_wdata got %h/%h want deadbeef/f", M_WDATA, M_WSTRB); end
        n_cmp++; if (DM_ACK !== 1'b1 || IF_ACK !== 1'b0 || ARB_DM_STALL !== 1'b0) begin n_err++; $display("FAIL ct_dm_ack got dm=%h if=%h st=%h want 1/0/0", DM_ACK, IF_ACK, ARB_DM_STALL); end
        next_cycle();                                        // cycle 2
        DM_REQ = 0; DM_WE = 0; M_ACK = 0;
        sample();
        n_cmp++; if (M_REQ !== 1'b0 || IF_ACK !== 1'b0) begin n_err++; $display("FAIL ct_bubble got req=%h ifack=%h want 0/0", M_REQ, IF_ACK); end
        next_cycle();                                        // cycle 3
        M_ACK = 1; M_RDATA = 32'h00A00113;
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_WE !== 1'b0 || M_ADDR !== 32'h104) begin n_err++; $display("FAIL ct_if_grant got req=%h we=%h addr=%h want 1/0/104", M_REQ, M_WE, M_ADDR); end
        n_cmp++; if (IF_ACK !== 1'b1 || IF_RDATA !== 32'h00A00113 || DM_ACK !== 1'b0) begin n_err++; $display("FAIL ct_if_ack got ack=%h data=%h dm=%h want 1/00a00113/0", IF_ACK, IF_RDATA, DM_ACK); end
        next_cycle();
        IF_REQ = 0; M_ACK = 0;
        next_cycle();
    endtask

    task automatic test_starvation();
        int dm_grants;
        dm_grants = 0;
        IF_REQ = 1; IF_ADDR = 32'h200;
        DM_REQ = 1; DM_WE = 0; DM_ADDR = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            M_ACK = 0;                                       // IDLE: DM wins
            next_cycle();
            M_ACK = 1; M_RDATA = 32'h5000 + k;
            sample();
            if (DM_ACK === 1'b1 && M_ADDR === 32'h3000) dm_grants++;
            n_cmp++; if (IF_ACK !== 1'b0) begin n_err++; $display("FAIL sv_if_early k=%0d got %h want 0", k, IF_ACK); end
            next_cycle();
        end
        n_cmp++; if (dm_grants !== 4) begin n_err++; $display("FAIL sv_dm_grants got %0d want 4", dm_grants); end
        M_ACK = 0;                                           // IDLE, count saturated
        next_cycle();
        M_ACK = 1; M_RDATA = 32'h00000013;
        sample();
        n_cmp++; if (IF_ACK !== 1'b1 || DM_ACK !== 1'b0 || M_ADDR !== 32'h200) begin n_err++; $display("FAIL sv_if_forced got if=%h dm=%h addr=%h want 1/0/200", IF_ACK, DM_ACK, M_ADDR); end
        next_cycle();
        IF_ADDR = 32'h204; M_ACK = 0;                        // IDLE, count cleared
        next_cycle();
        M_ACK = 1;
        sample();
        n_cmp++; if (DM_ACK !== 1'b1 || IF_ACK !== 1'b0 || M_ADDR !== 32'h3000) begin n_err++; $display("FAIL sv_count_reset got dm=%h if=%h addr=%h want 1/0/3000", DM_ACK, IF_ACK, M_ADDR); end
        next_cycle();
        DM_REQ = 0; M_ACK = 0;
        next_cycle();
        M_ACK = 1;
        sample();
        n_cmp++; if (IF_ACK !== 1'b1 || M_ADDR !== 32'h204) begin n_err++; $display("FAIL sv_if_after got if=%h addr=%h want 1/204", IF_ACK, M_ADDR); end
        next_cycle();
        IF_REQ = 0; M_ACK = 0;
        next_cycle();
    endtask

    task automatic test_flush_drain();
        IF_REQ = 1; IF_ADDR = 32'h300; DM_ADDR = 32'h3100; DM_WE = 0;   // cycle 0
        next_cycle();                                        // cycle 1: IF_BUSY
        next_cycle();                                        // cycle 2
        next_cycle();                                        // cycle 3
        IF_FLUSH = 1; DM_REQ = 1;
        sample();
        n_cmp++; if (IF_ACK !== 1'b0 || M_REQ !== 1'b1 || M_ADDR !== 32'h300) begin n_err++; $display("FAIL fd_c3 got ack=%h req=%h addr=%h want 0/1/300", IF_ACK, M_REQ, M_ADDR); end
        next_cycle();                                        // cycle 4: IF_DRAIN
        IF_FLUSH = 0; M_ACK = 1; M_RDATA = 32'hBAD0BAD0;
        sample();
        n_cmp++; if (IF_ACK !== 1'b0 || DM_ACK !== 1'b0 || M_REQ !== 1'b1) begin n_err++; $display("FAIL fd_drain_ack got if=%h dm=%h req=%h want 0/0/1", IF_ACK, DM_ACK, M_REQ); end
        n_cmp++; if (ARB_IF_STALL !== 1'b1) begin n_err++; $display("FAIL fd_stall got %h want 1", ARB_IF_STALL); end
        next_cycle();                                        // cycle 5: bubble
        IF_REQ = 0; M_ACK = 0;
        sample();
        n_cmp++; if (M_REQ !== 1'b0 || IF_ACK !== 1'b0) begin n_err++; $display("FAIL fd_bubble got req=%h if=%h want 0/0", M_REQ, IF_ACK); end
        next_cycle();                                        // cycle 6
        M_ACK = 1; M_RDATA = 32'h77;
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_ADDR !== 32'h3100 || DM_ACK !== 1'b1 || DM_RDATA !== 32'h77) begin n_err++; $display("FAIL fd_dm got req=%h addr=%h ack=%h data=%h want 1/3100/1/77", M_REQ, M_ADDR, DM_ACK, DM_RDATA); end
        next_cycle();
        DM_REQ = 0; M_ACK = 0;
        next_cycle();
    endtask

    task automatic test_flush_with_ack();
        IF_REQ = 1; IF_ADDR = 32'h400;                       // cycle 0
        next_cycle();                                        // cycle 1
        IF_FLUSH = 1; M_ACK = 1;
        sample();
        n_cmp++; if (IF_ACK !== 1'b0) begin n_err++; $display("FAIL fa_ack_suppressed got %h want 0", IF_ACK); end
        next_cycle();                                        // cycle 2: IDLE, flush blocks grant
        M_ACK = 0;
        sample();
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL fa_idle got %h want 0", M_REQ); end
        next_cycle();                                        // cycle 3
        IF_FLUSH = 0;
        sample();
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL fa_no_grant got %h want 0", M_REQ); end
        IF_REQ = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        DM_REQ = 1; DM_WE = 1; DM_ADDR = 32'h4000; DM_WDATA = 32'h12345678; DM_WSTRB = 4'h3;
        next_cycle();                                        // DM_BUSY
        sample();
        n_cmp++; if (M_REQ !== 1'b1 || M_ADDR !== 32'h4000) begin n_err++; $display("FAIL rm_busy got req=%h addr=%h want 1/4000", M_REQ, M_ADDR); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (M_REQ !== 1'b0) begin n_err++; $display("FAIL rm_async_req got %h want 0", M_REQ); end
        n_cmp++; if ({M_WE, M_ADDR, M_WDATA, M_WSTRB} !== '0) begin n_err++; $display("FAIL rm_async_bus got %h/%h/%h/%h want all 0", M_WE, M_ADDR, M_WDATA, M_WSTRB); end
        DM_REQ = 0; DM_WE = 0;
        next_cycle();
        RST = 1'b0; M_ACK = 1;
        sample();
        n_cmp++; if (DM_ACK !== 1'b0 || M_REQ !== 1'b0) begin n_err++; $display("FAIL rm_no_ack got ack=%h req=%h want 0/0", DM_ACK, M_REQ); end
        next_cycle();
        M_ACK = 0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            IF_REQ = 1; IF_ADDR = 32'h1000 + 4 * i; M_ACK = 0;
            sample();
            n_cmp++; if (IF_ACK !== 1'b0 || M_REQ !== 1'b0) begin n_err++; $display("FAIL bb_idle i=%0d got ack=%h req=%h want 0/0", i, IF_ACK, M_REQ); end
            next_cycle();
            M_ACK = 1; M_RDATA = 32'hA0000000 + i;
            sample();
            if (IF_ACK === 1'b1) acks++;
            n_cmp++; if (M_ADDR !== 32'h1000 + 4 * i || IF_RDATA !== 32'hA0000000 + i || (IF_ACK & DM_ACK) !== 1'b0) begin n_err++; $display("FAIL bb_fetch i=%0d got addr=%h data=%h dm=%h want %h/%h/0", i, M_ADDR, IF_RDATA, DM_ACK, 32'h1000 + 4 * i, 32'hA0000000 + i); end
            next_cycle();
        end
        IF_REQ = 0; M_ACK = 0;
        n_cmp++; if (acks !== 8) begin n_err++; $display("FAIL bb_ack_count got %0d want 8", acks); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_flush_drain();
        test_flush_with_ack();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
